// File: rtl/archie_kbd_pkg.sv
// Shared constants, state encoding and FIFO entry layout for the
// Archimedes keyboard-side protocol engine.
package archie_kbd_pkg;

  localparam logic [7:0] HRST = 8'hFF;
  localparam logic [7:0] RAK1 = 8'hFE;
  localparam logic [7:0] RAK2 = 8'hFD;
  localparam logic [7:0] RQID = 8'h20;
  localparam logic [7:0] PRST = 8'h21;
  localparam logic [7:0] BACK = 8'h3F;
  localparam logic [7:0] NACK = 8'h30;
  localparam logic [7:0] SACK = 8'h31;
  localparam logic [7:0] MACK = 8'h32;
  localparam logic [7:0] SMAK = 8'h33;

  localparam logic [3:0] KEYDN = 4'hC;
  localparam logic [3:0] KEYUP = 4'hD;

  typedef logic [3:0] state_t;

  localparam state_t ST_SYNC    = 4'd0;
  localparam state_t ST_TX_HRST = 4'd1;
  localparam state_t ST_W_RAK1  = 4'd2;
  localparam state_t ST_TX_RAK1 = 4'd3;
  localparam state_t ST_W_RAK2  = 4'd4;
  localparam state_t ST_TX_RAK2 = 4'd5;
  localparam state_t ST_W_ACK   = 4'd6;
  localparam state_t ST_IDLE    = 4'd7;
  localparam state_t ST_TX_B1   = 4'd8;
  localparam state_t ST_W_BACK  = 4'd9;
  localparam state_t ST_TX_B2   = 4'd10;
  localparam state_t ST_W_FACK  = 4'd11;
  localparam state_t ST_TX_KBID = 4'd12;

  typedef struct packed {
    logic       up;
    logic [3:0] row;
    logic [3:0] col;
  } key_entry_t;

  // NACK/SACK/MACK/SMAK: bit 0 is the key enable, bit 1 the mouse enable.
  function automatic logic is_ack(input logic [7:0] b);
    return b[7:2] == 6'b001100;
  endfunction

  function automatic logic [6:0] sat_add(input logic [6:0] acc, input logic [7:0] d);
    logic signed [8:0] s;
    s = $signed({{2{acc[6]}}, acc}) + $signed({d[7], d});
    if (s > 9'sd63) return 7'h3F;
    else if (s < -9'sd64) return 7'h40;
    else return s[6:0];
  endfunction

endpackage

// File: rtl/archie_kbd_fifo.sv
// Small synchronous key-event FIFO; the head is visible combinationally so
// a transfer can be retried without popping.
module archie_kbd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok, pop_ok;

  assign full    = count_reg == (AW+1)'(DEPTH);
  assign empty   = count_reg == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/archie_kbd_proto.sv
// Keyboard-side Archimedes link engine: reset handshake, acknowledged
// two-byte key/mouse transfers, RQID and LED commands, paced by a gap counter.
module archie_kbd_proto
  import archie_kbd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         TX_GAP     = 2048,
  parameter logic [7:0] KBID       = 8'h81
) (
  input  logic       clkcpu,
  input  logic       rst_n_i,
  input  logic       key_stb,
  input  logic       key_up,
  input  logic [3:0] key_row,
  input  logic [3:0] key_col,
  input  logic       mouse_stb,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy,
  input  logic [7:0] kbd_out_data,
  input  logic       kbd_out_strobe,
  output logic [7:0] kbd_in_data,
  output logic       kbd_in_strobe,
  output logic [2:0] leds,
  output logic       key_ovf
);
  localparam int GW = $clog2(TX_GAP + 1);

  state_t        state_reg, state_next;
  logic [GW-1:0] gap_reg;
  logic          key_en_reg, mouse_en_reg, mouse_xfer_reg;
  logic [6:0]    acc_x_reg, acc_y_reg, lat_x_reg, lat_y_reg;
  logic [7:0]    kbd_in_data_reg;
  logic          kbd_in_strobe_reg, key_ovf_reg;
  logic [2:0]    leds_reg;

  key_entry_t    head;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic          host_hrst, host_ack, tx_state, tx_go, start_key, start_mouse;
  logic [3:0]    prefix;
  logic [7:0]    tx_byte;

  assign host_hrst   = kbd_out_strobe && (kbd_out_data == HRST);
  assign host_ack    = kbd_out_strobe && is_ack(kbd_out_data);
  assign tx_state    = state_reg inside {ST_TX_HRST, ST_TX_RAK1, ST_TX_RAK2,
                                         ST_TX_B1, ST_TX_B2, ST_TX_KBID};
  // A host reset in the issuing cycle kills the byte before it leaves.
  assign tx_go       = tx_state && (gap_reg == '0) && !host_hrst;
  assign start_key   = (state_reg == ST_IDLE) && !kbd_out_strobe && key_en_reg && !fifo_empty;
  assign start_mouse = (state_reg == ST_IDLE) && !kbd_out_strobe && !start_key &&
                       mouse_en_reg && ((acc_x_reg != '0) || (acc_y_reg != '0));
  assign fifo_push   = key_stb && !host_hrst;
  assign fifo_pop    = (state_reg == ST_W_FACK) && host_ack && !mouse_xfer_reg;
  assign prefix      = head.up ? KEYUP : KEYDN;

  archie_kbd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(key_entry_t))) u_fifo (
    .clk   (clkcpu),
    .rst_n (rst_n_i),
    .flush (host_hrst),
    .push  (fifo_push),
    .din   ({key_up, key_row, key_col}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    tx_byte = 8'h00;
    case (state_reg)
      ST_TX_HRST: tx_byte = HRST;
      ST_TX_RAK1: tx_byte = RAK1;
      ST_TX_RAK2: tx_byte = RAK2;
      ST_TX_KBID: tx_byte = KBID;
      ST_TX_B1:   tx_byte = mouse_xfer_reg ? {1'b0, lat_x_reg} : {prefix, head.row};
      ST_TX_B2:   tx_byte = mouse_xfer_reg ? {1'b0, lat_y_reg} : {prefix, head.col};
      default:    tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (host_hrst) begin
      state_next = ST_TX_HRST;
    end else if (tx_go) begin
      case (state_reg)
        ST_TX_HRST: state_next = ST_W_RAK1;
        ST_TX_RAK1: state_next = ST_W_RAK2;
        ST_TX_RAK2: state_next = ST_W_ACK;
        ST_TX_B1:   state_next = ST_W_BACK;
        ST_TX_B2:   state_next = ST_W_FACK;
        default:    state_next = ST_IDLE;
      endcase
    end else if (kbd_out_strobe) begin
      case (state_reg)
        ST_W_RAK1: state_next = (kbd_out_data == RAK1) ? ST_TX_RAK1 : ST_TX_HRST;
        ST_W_RAK2: state_next = (kbd_out_data == RAK2) ? ST_TX_RAK2 : ST_TX_HRST;
        ST_W_ACK:  state_next = host_ack ? ST_IDLE : ST_TX_HRST;
        ST_IDLE:   if (kbd_out_data == RQID) state_next = ST_TX_KBID;
        ST_W_BACK: state_next = (kbd_out_data == BACK) ? ST_TX_B2 : ST_TX_HRST;
        ST_W_FACK: state_next = host_ack ? ST_IDLE : ST_TX_HRST;
        default:   state_next = state_reg;
      endcase
    end else if (start_key || start_mouse) begin
      state_next = ST_TX_B1;
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg         <= ST_SYNC;
      gap_reg           <= GW'(TX_GAP);
      key_en_reg        <= 1'b0;
      mouse_en_reg      <= 1'b0;
      mouse_xfer_reg    <= 1'b0;
      acc_x_reg         <= '0;
      acc_y_reg         <= '0;
      lat_x_reg         <= '0;
      lat_y_reg         <= '0;
      kbd_in_data_reg   <= 8'h00;
      kbd_in_strobe_reg <= 1'b0;
      key_ovf_reg       <= 1'b0;
      leds_reg          <= 3'b000;
    end else begin
      state_reg         <= state_next;
      kbd_in_strobe_reg <= tx_go;
      key_ovf_reg       <= key_stb && fifo_full && !host_hrst;
      if (tx_go) kbd_in_data_reg <= tx_byte;

      if (kbd_out_strobe || tx_go) gap_reg <= GW'(TX_GAP);
      else if (gap_reg != '0) gap_reg <= gap_reg - 1'b1;

      if (host_hrst) begin
        key_en_reg   <= 1'b0;
        mouse_en_reg <= 1'b0;
      end else if (host_ack && (state_reg inside {ST_W_ACK, ST_IDLE, ST_W_FACK})) begin
        key_en_reg   <= kbd_out_data[0];
        mouse_en_reg <= kbd_out_data[1];
      end

      if (kbd_out_strobe && (state_reg == ST_IDLE) && (kbd_out_data[7:3] == 5'b0))
        leds_reg <= kbd_out_data[2:0];

      if (start_key) mouse_xfer_reg <= 1'b0;

      // Starting a mouse transfer snapshots the totals; a same-cycle delta
      // seeds the next accumulation rather than being lost.
      if (host_hrst) begin
        acc_x_reg <= '0;
        acc_y_reg <= '0;
      end else if (start_mouse) begin
        mouse_xfer_reg <= 1'b1;
        lat_x_reg      <= acc_x_reg;
        lat_y_reg      <= acc_y_reg;
        acc_x_reg      <= mouse_stb ? sat_add(7'd0, mouse_dx) : 7'd0;
        acc_y_reg      <= mouse_stb ? sat_add(7'd0, mouse_dy) : 7'd0;
      end else if (mouse_stb) begin
        acc_x_reg <= sat_add(acc_x_reg, mouse_dx);
        acc_y_reg <= sat_add(acc_y_reg, mouse_dy);
      end
    end
  end

  assign kbd_in_data   = kbd_in_data_reg;
  assign kbd_in_strobe = kbd_in_strobe_reg;
  assign leds          = leds_reg;
  assign key_ovf       = key_ovf_reg;

endmodule

// File: tb/tb_archie_kbd_proto.sv
// Directed bench for archie_kbd_proto: an IOC-side model drives host bytes and
// checks every keyboard byte against hand-computed tables.
module tb_archie_kbd_proto;
  localparam int GAP = 16;

  logic       clkcpu = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       key_stb = 1'b0, key_up = 1'b0;
  logic [3:0] key_row = '0, key_col = '0;
  logic       mouse_stb = 1'b0;
  logic [7:0] mouse_dx = '0, mouse_dy = '0;
  logic [7:0] kbd_out_data = '0;
  logic       kbd_out_strobe = 1'b0;
  logic [7:0] kbd_in_data;
  logic       kbd_in_strobe;
  logic [2:0] leds;
  logic       key_ovf;

  archie_kbd_proto #(.FIFO_DEPTH(8), .TX_GAP(GAP), .KBID(8'h81)) dut (
    .clkcpu(clkcpu), .rst_n_i(rst_n_i),
    .key_stb(key_stb), .key_up(key_up), .key_row(key_row), .key_col(key_col),
    .mouse_stb(mouse_stb), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
    .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
    .leds(leds), .key_ovf(key_ovf)
  );

  always #5 clkcpu = ~clkcpu;

  int         checks = 0, errors = 0;
  int         cyc = 0;
  int         last_strobe = -100000;
  int         ovf_pulses = 0;
  logic [7:0] rxq[$];

  typedef struct {
    string      name;
    bit         has_host;
    logic [7:0] host;
    bit         exp_rx;
    logic [7:0] rx;
  } step_t;
  step_t tbl[$];

  typedef struct { logic up; logic [3:0] row; logic [3:0] col; } key_t;
  key_t expq[$];

  always @(posedge clkcpu) cyc++;

  // IOC monitor: captures bytes and enforces the inter-strobe gap.
  always @(negedge clkcpu) begin
    if (rst_n_i && kbd_in_strobe) begin
      checks++;
      if (cyc - last_strobe < GAP) begin
        errors++;
        $display("FAIL gap: actual %0d cycles required >= %0d", cyc - last_strobe, GAP);
      end
      $display("rx byte %02h at cycle %0d", kbd_in_data, cyc);
      rxq.push_back(kbd_in_data);
      last_strobe = cyc;
    end
    if (kbd_out_strobe) last_strobe = cyc;
    if (key_ovf) ovf_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic host_send(input logic [7:0] b);
    @(posedge clkcpu); #1;
    kbd_out_data = b; kbd_out_strobe = 1'b1;
    $display("tx host byte %02h", b);
    @(posedge clkcpu); #1;
    kbd_out_strobe = 1'b0;
  endtask

  task automatic key_event(input logic up, input logic [3:0] row, input logic [3:0] col);
    @(posedge clkcpu); #1;
    key_stb = 1'b1; key_up = up; key_row = row; key_col = col;
    @(posedge clkcpu); #1;
    key_stb = 1'b0;
  endtask

  task automatic mouse_event(input logic [7:0] dx, input logic [7:0] dy);
    @(posedge clkcpu); #1;
    mouse_stb = 1'b1; mouse_dx = dx; mouse_dy = dy;
    @(posedge clkcpu); #1;
    mouse_stb = 1'b0;
  endtask

  task automatic expect_rx(input string name, input logic [7:0] exp);
    int n;
    logic [7:0] b;
    n = 0;
    while (rxq.size() == 0 && n < 400) begin
      @(posedge clkcpu);
      n++;
    end
    if (rxq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: actual none required %02h", name, exp);
    end else begin
      b = rxq.pop_front();
      chk(name, {24'h0, b}, {24'h0, exp});
    end
  endtask

  task automatic expect_quiet(input string name);
    repeat (3 * GAP) @(posedge clkcpu);
    chk(name, rxq.size(), 0);
    rxq.delete();
  endtask

  function automatic step_t st(input string n, input bit hh, input logic [7:0] h,
                               input bit er, input logic [7:0] r);
    step_t s;
    s.name = n; s.has_host = hh; s.host = h; s.exp_rx = er; s.rx = r;
    return s;
  endfunction

  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].has_host) host_send(tbl[i].host);
      if (tbl[i].exp_rx) expect_rx(tbl[i].name, tbl[i].rx);
      else expect_quiet(tbl[i].name);
    end
    tbl.delete();
  endtask

  task automatic key_pair(input string name, input key_t k);
    logic [3:0] p;
    p = k.up ? 4'hD : 4'hC;
    expect_rx({name, "_b1"}, {p, k.row});
    host_send(8'h3F);
    expect_rx({name, "_b2"}, {p, k.col});
    host_send(8'h31);
  endtask

  initial begin
    key_t k;
    repeat (3) @(posedge clkcpu);
    #1;
    chk("rst_data", {24'h0, kbd_in_data}, 0);
    chk("rst_strobe", {31'h0, kbd_in_strobe}, 0);
    chk("rst_leds", {29'h0, leds}, 0);
    chk("rst_ovf", {31'h0, key_ovf}, 0);
    rst_n_i = 1'b1;

    // Handshake; a non-HRST byte in SYNC is ignored.
    tbl.push_back(st("sync_ignore", 1, 8'hFE, 0, 8'h00));
    tbl.push_back(st("hs_hrst", 1, 8'hFF, 1, 8'hFF));
    tbl.push_back(st("hs_rak1", 1, 8'hFE, 1, 8'hFE));
    tbl.push_back(st("hs_rak2", 1, 8'hFD, 1, 8'hFD));
    tbl.push_back(st("hs_smak", 1, 8'h33, 0, 8'h00));
    run_tbl();

    // Key press then release.
    key_event(1'b0, 4'd3, 4'd5);
    tbl.push_back(st("kp_b1", 0, 8'h00, 1, 8'hC3));
    tbl.push_back(st("kp_b2", 1, 8'h3F, 1, 8'hC5));
    tbl.push_back(st("kp_fack", 1, 8'h31, 0, 8'h00));
    run_tbl();
    key_event(1'b1, 4'd3, 4'd5);
    tbl.push_back(st("kr_b1", 0, 8'h00, 1, 8'hD3));
    tbl.push_back(st("kr_b2", 1, 8'h3F, 1, 8'hD5));
    tbl.push_back(st("kr_fack", 1, 8'h33, 0, 8'h00));
    // IDLE commands.
    tbl.push_back(st("rqid", 1, 8'h20, 1, 8'h81));
    tbl.push_back(st("leds05", 1, 8'h05, 0, 8'h00));
    run_tbl();
    chk("leds_101", {29'h0, leds}, 32'h5);
    tbl.push_back(st("prst", 1, 8'h21, 0, 8'h00));
    run_tbl();
    chk("leds_after_prst", {29'h0, leds}, 32'h5);
    tbl.push_back(st("leds00", 1, 8'h00, 0, 8'h00));
    run_tbl();
    chk("leds_000", {29'h0, leds}, 32'h0);

    // Mouse: accumulate with enables off, then SMAK starts the transfer.
    tbl.push_back(st("m_nack", 1, 8'h30, 0, 8'h00));
    run_tbl();
    mouse_event(8'd50, 8'hFD);
    mouse_event(8'd50, 8'h00);
    tbl.push_back(st("m_x_clamp", 1, 8'h33, 1, 8'h3F));
    tbl.push_back(st("m_y", 1, 8'h3F, 1, 8'h7D));
    tbl.push_back(st("m_acc_zero", 1, 8'h33, 0, 8'h00));
    run_tbl();
    mouse_event(8'h9C, 8'h00);  // -100 clamps to -64
    tbl.push_back(st("m_x_neg", 0, 8'h00, 1, 8'h40));
    tbl.push_back(st("m_y_zero", 1, 8'h3F, 1, 8'h00));
    tbl.push_back(st("m_neg_done", 1, 8'h33, 0, 8'h00));
    tbl.push_back(st("ovf_nack", 1, 8'h30, 0, 8'h00));
    run_tbl();

    // Overflow: nine back-to-back events into an eight-entry FIFO.
    ovf_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clkcpu); #1;
      key_stb = 1'b1; key_up = i[0]; key_row = 4'(i); key_col = 4'(i + 1);
      k.up = i[0]; k.row = 4'(i); k.col = 4'(i + 1);
      if (expq.size() < 8) expq.push_back(k);
    end
    @(posedge clkcpu); #1;
    key_stb = 1'b0;
    repeat (4) @(posedge clkcpu);
    chk("ovf_pulses", ovf_pulses, 1);
    host_send(8'h31);
    while (expq.size() > 0) begin
      k = expq.pop_front();
      key_pair($sformatf("ovf_pair%0d", k.row), k);
    end
    expect_quiet("ovf_drained");
    chk("ovf_total", ovf_pulses, 1);

    // Protocol error: NACK instead of BACK forces a reset; head retained.
    key_event(1'b0, 4'd3, 4'd5);
    tbl.push_back(st("err_b1", 0, 8'h00, 1, 8'hC3));
    tbl.push_back(st("err_hrst", 1, 8'h30, 1, 8'hFF));
    tbl.push_back(st("err_rak1", 1, 8'hFE, 1, 8'hFE));
    tbl.push_back(st("err_rak2", 1, 8'hFD, 1, 8'hFD));
    tbl.push_back(st("err_retry_b1", 1, 8'h31, 1, 8'hC3));
    tbl.push_back(st("err_retry_b2", 1, 8'h3F, 1, 8'hC5));
    tbl.push_back(st("err_done", 1, 8'h31, 0, 8'h00));
    run_tbl();

    // HRST mid-transfer flushes the FIFO.
    key_event(1'b0, 4'd7, 4'd1);
    key_event(1'b0, 4'd2, 4'd2);
    tbl.push_back(st("hr_b1", 0, 8'h00, 1, 8'hC7));
    tbl.push_back(st("hr_hrst", 1, 8'hFF, 1, 8'hFF));
    tbl.push_back(st("hr_rak1", 1, 8'hFE, 1, 8'hFE));
    tbl.push_back(st("hr_rak2", 1, 8'hFD, 1, 8'hFD));
    tbl.push_back(st("hr_flushed", 1, 8'h31, 0, 8'h00));
    run_tbl();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
